// File: rtl/sram_pkg.sv
// Shared constants and helpers for the SRAM read/write parity blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_pkg;

   // Default geometry of the SRAM read-return path.
   localparam int DATA_W_DEF = 32;
   localparam int LANE_W_DEF = 8;
   localparam int ADDR_W_DEF = 16;
   localparam int CNT_W_DEF  = 8;

   // Parity polarity: 0 selects even parity (XOR of lane plus parity bit is 0).
   localparam logic PARITY_ODD = 1'b0;

   // Number of parity bits protecting a data word.
   function automatic int par_w(input int data_w, input int lane_w);
      return data_w / lane_w;
   endfunction

endpackage

// File: rtl/sram_lane_parity.sv
// Per-lane parity generator: one parity bit per LANE_W-bit slice of data.
// Latency: 0 cycles, purely combinational.
// Backpressure: none, output follows input.
module sram_lane_parity
   import sram_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int LANE_W = LANE_W_DEF,
   localparam int PAR_W  = par_w(DATA_W, LANE_W)
) (
   input  logic [DATA_W-1:0] data,
   output logic [PAR_W-1:0]  parity
);

   // XOR-reduce each lane; polarity constant lets the write side share this block.
   always_comb begin
      parity = '0;
      for (int i = 0; i < PAR_W; i++) begin
         parity[i] = (^data[i*LANE_W +: LANE_W]) ^ PARITY_ODD;
      end
   end

endmodule

// File: rtl/sram_parity_checker.sv
// SRAM read-return parity checker: flags per-lane mismatches, keeps sticky status/count/first address.
// Latency: 2 cycles fixed (input register, then check + output register), one beat per cycle.
// Backpressure: none, every in_valid beat is accepted. Optional macro SRAM_PARITY_ERR_INJECT_EN adds parity error injection.
module sram_parity_checker
   import sram_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int LANE_W = LANE_W_DEF,
   parameter  int ADDR_W = ADDR_W_DEF,
   parameter  int CNT_W  = CNT_W_DEF,
   localparam int PAR_W  = par_w(DATA_W, LANE_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PAR_W-1:0]  in_parity,
   input  logic              clr_err,
`ifdef SRAM_PARITY_ERR_INJECT_EN
   input  logic              inj_arm,
   input  logic [PAR_W-1:0]  inj_mask,
`endif
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [PAR_W-1:0]  out_err_mask,
   output logic              out_err,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_count,
   output logic              err_first_valid,
   output logic [ADDR_W-1:0] err_first_addr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Stage 1 registers.
   logic              s1_valid;
   logic [ADDR_W-1:0] s1_addr;
   logic [DATA_W-1:0] s1_data;
   logic [PAR_W-1:0]  s1_parity;

   // Parity entering stage 1 (possibly with an injected error pattern).
   logic [PAR_W-1:0]  s1_parity_d;

   // Stage 2 combinational check results.
   logic [PAR_W-1:0]  s2_calc;
   logic [PAR_W-1:0]  s2_mask;
   logic              s2_err_beat;

`ifdef SRAM_PARITY_ERR_INJECT_EN
   logic              inj_armed;
   logic [PAR_W-1:0]  inj_mask_q;
   logic              inj_live;
   logic [PAR_W-1:0]  inj_sel;

   // A same-cycle arm takes priority so arm and beat together hit that beat.
   assign inj_live    = inj_arm | inj_armed;
   assign inj_sel     = inj_arm ? inj_mask : inj_mask_q;
   assign s1_parity_d = in_parity ^ (inj_live ? inj_sel : '0);

   // Arm register: consumed by the next accepted beat, re-arm replaces the mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inj_armed  <= 1'b0;
         inj_mask_q <= '0;
      end else if (in_valid) begin
         inj_armed  <= 1'b0;
      end else if (inj_arm) begin
         inj_armed  <= 1'b1;
         inj_mask_q <= inj_mask;
      end
   end
`else
   assign s1_parity_d = in_parity;
`endif

   // Stage 1 valid: reset discards any beat in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
      end
   end

   // Stage 1 payload: only loaded on a valid beat, never observed unless s1_valid.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         s1_addr   <= in_addr;
         s1_data   <= in_data;
         s1_parity <= s1_parity_d;
      end
   end

   sram_lane_parity #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_lane_parity (
      .data   (s1_data),
      .parity (s2_calc)
   );

   assign s2_mask     = s2_calc ^ s1_parity;
   assign s2_err_beat = s1_valid & (|s2_mask);

   // Stage 2 output register: mask/err forced low on idle cycles, data/addr hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_addr     <= '0;
         out_data     <= '0;
         out_err_mask <= '0;
         out_err      <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         out_err   <= s2_err_beat;
         if (s1_valid) begin
            out_addr     <= s1_addr;
            out_data     <= s1_data;
            out_err_mask <= s2_mask;
         end else begin
            out_err_mask <= '0;
         end
      end
   end

   // Debug status: a clear coincident with an error beat restarts from that beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky      <= 1'b0;
         err_count       <= '0;
         err_first_valid <= 1'b0;
         err_first_addr  <= '0;
      end else if (clr_err) begin
         err_sticky      <= s2_err_beat;
         err_count       <= s2_err_beat ? CNT_W'(1) : '0;
         err_first_valid <= s2_err_beat;
         err_first_addr  <= s2_err_beat ? s1_addr : '0;
      end else if (s2_err_beat) begin
         err_sticky <= 1'b1;
         if (err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
         end
         if (!err_first_valid) begin
            err_first_valid <= 1'b1;
            err_first_addr  <= s1_addr;
         end
      end
   end

endmodule

// File: tb/tb_sram_parity_checker.sv
// Directed bench for sram_parity_checker with a scoreboard of expected beats.
// Latency: expects each beat two cycles after it is driven.
// Backpressure: none exercised, the DUT never stalls.
module tb_sram_parity_checker;

   localparam int DATA_W = 32;
   localparam int LANE_W = 8;
   localparam int ADDR_W = 16;
   localparam int CNT_W  = 4;
   localparam int PAR_W  = DATA_W / LANE_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [PAR_W-1:0]  mask;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic [PAR_W-1:0]  in_parity;
   logic              clr_err;
`ifdef SRAM_PARITY_ERR_INJECT_EN
   logic              inj_arm;
   logic [PAR_W-1:0]  inj_mask;
`endif
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic [PAR_W-1:0]  out_err_mask;
   logic              out_err;
   logic              err_sticky;
   logic [CNT_W-1:0]  err_count;
   logic              err_first_valid;
   logic [ADDR_W-1:0] err_first_addr;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   sram_parity_checker #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_addr         (in_addr),
      .in_data         (in_data),
      .in_parity       (in_parity),
      .clr_err         (clr_err),
`ifdef SRAM_PARITY_ERR_INJECT_EN
      .inj_arm         (inj_arm),
      .inj_mask        (inj_mask),
`endif
      .out_valid       (out_valid),
      .out_addr        (out_addr),
      .out_data        (out_data),
      .out_err_mask    (out_err_mask),
      .out_err         (out_err),
      .err_sticky      (err_sticky),
      .err_count       (err_count),
      .err_first_valid (err_first_valid),
      .err_first_addr  (err_first_addr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Even parity reference: mismatch where lane XOR differs from the stored bit.
   function automatic logic [PAR_W-1:0] model_mask(input logic [DATA_W-1:0] d,
                                                    input logic [PAR_W-1:0] p);
      logic [PAR_W-1:0] m;
      m = '0;
      for (int i = 0; i < PAR_W; i++) m[i] = (^d[i*LANE_W +: LANE_W]) ^ p[i];
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat for one cycle and push its expected result; inj is the
   // parity pattern the DUT is expected to fold in on top of p.
   task automatic beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [PAR_W-1:0] p, input logic [PAR_W-1:0] inj);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.mask = model_mask(d, p ^ inj);
      sb.push_back(e);
      in_valid  = 1'b1;
      in_addr   = a;
      in_data   = d;
      in_parity = p;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic drain();
      repeat (3) tick();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_status(input string tag, input logic s, input logic [CNT_W-1:0] c,
                             input logic fv, input logic [ADDR_W-1:0] fa);
      chk({tag, "_sticky"}, 64'(err_sticky), 64'(s));
      chk({tag, "_count"}, 64'(err_count), 64'(c));
      chk({tag, "_first_valid"}, 64'(err_first_valid), 64'(fv));
      if (fv) chk({tag, "_first_addr"}, 64'(err_first_addr), 64'(fa));
   endtask

   // Output monitor: every out_valid beat must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("out_addr", 64'(out_addr), 64'(e.addr));
               chk("out_data", 64'(out_data), 64'(e.data));
               chk("out_err_mask", 64'(out_err_mask), 64'(e.mask));
               chk("out_err", 64'(out_err), 64'(|e.mask));
            end
         end else begin
            chk("idle_err_mask", 64'(out_err_mask), 64'd0);
            chk("idle_err", 64'(out_err), 64'd0);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      logic [PAR_W-1:0]  p;

      // Reset held for two cycles with a live (erroring) input beat.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_addr   = 16'h0BAD;
      in_data   = 32'hFFFF_FFFF;
      in_parity = 4'b0001;
      clr_err   = 1'b0;
`ifdef SRAM_PARITY_ERR_INJECT_EN
      inj_arm   = 1'b0;
      inj_mask  = '0;
`endif
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_out_err_mask", 64'(out_err_mask), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk_status("rst", 1'b0, 4'd0, 1'b0, 16'h0);
      chk("rst_first_addr", 64'(err_first_addr), 64'd0);

      // Mid-stream reset: a beat accepted then reset must never emerge.
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk_status("midrst", 1'b0, 4'd0, 1'b0, 16'h0);

      // Clean beat: latency 2, no error.
      beat(16'h0010, 32'hFFFF_FFFF, 4'b0000, 4'b0000);
      chk("latency_one_cycle_no_valid", 64'(out_valid), 64'd0);
      drain();
      chk_status("clean", 1'b0, 4'd0, 1'b0, 16'h0);

      // Two error beats: first address captured and kept.
      beat(16'h0020, 32'hFFFF_FFFF, 4'b0001, 4'b0000);
      drain();
      chk_status("err1", 1'b1, 4'd1, 1'b1, 16'h0020);
      beat(16'h0030, 32'h0000_0100, 4'b0000, 4'b0000);
      drain();
      chk_status("err2", 1'b1, 4'd2, 1'b1, 16'h0020);

      // Back-to-back beats, lanes 0..3 corrupted in turn.
      for (int i = 0; i < PAR_W; i++) begin
         beat(16'h0100 + 16'(i), 32'h0000_0000, 4'b0001 << i, 4'b0000);
      end
      chk("b2b_valid_3", 64'(out_valid), 64'd1);
      tick();
      chk("b2b_valid_4", 64'(out_valid), 64'd1);
      tick();
      chk("b2b_idle_after", 64'(out_valid), 64'd0);
      drain();
      chk_status("b2b", 1'b1, 4'd6, 1'b1, 16'h0020);

      // Saturation: 20 more error beats on a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         p = model_mask(d, 4'b0000) ^ (4'b0001 << (i % PAR_W));
         beat(16'h0200 + 16'(i), d, p, 4'b0000);
      end
      drain();
      chk_status("sat", 1'b1, 4'd15, 1'b1, 16'h0020);
      beat(16'h0300, 32'h0000_0001, 4'b0000, 4'b0000);
      beat(16'h0301, 32'h0000_0003, 4'b0001, 4'b0000);
      drain();
      chk_status("sat_hold", 1'b1, 4'd15, 1'b1, 16'h0020);

      // Clear alone.
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk_status("clr", 1'b0, 4'd0, 1'b0, 16'h0);

      // Clear coincident with an error beat reaching the output stage.
      beat(16'h0050, 32'h0000_0000, 4'b0100, 4'b0000);
      drain();
      chk_status("pre_coinc", 1'b1, 4'd1, 1'b1, 16'h0050);
      beat(16'h0040, 32'h0000_0000, 4'b1000, 4'b0000);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      drain();
      chk_status("coinc", 1'b1, 4'd1, 1'b1, 16'h0040);

`ifdef SRAM_PARITY_ERR_INJECT_EN
      // Arm alone, then the next beat takes the pattern and the one after is clean.
      inj_arm  = 1'b1;
      inj_mask = 4'b0100;
      tick();
      inj_arm  = 1'b0;
      beat(16'h0060, 32'h1234_5678, model_mask(32'h1234_5678, 4'b0000), 4'b0100);
      beat(16'h0061, 32'h1234_5678, model_mask(32'h1234_5678, 4'b0000), 4'b0000);
      drain();
      // Arm and beat in the same cycle.
      inj_arm  = 1'b1;
      inj_mask = 4'b0010;
      beat(16'h0062, 32'h0000_0000, 4'b0000, 4'b0010);
      inj_arm  = 1'b0;
      // Re-arm replaces the pending mask.
      inj_arm  = 1'b1;
      inj_mask = 4'b0001;
      tick();
      inj_mask = 4'b1000;
      tick();
      inj_arm  = 1'b0;
      beat(16'h0063, 32'h0000_0000, 4'b0000, 4'b1000);
      beat(16'h0064, 32'h0000_0000, 4'b0000, 4'b0000);
      drain();
      chk_status("inject", 1'b1, 4'd4, 1'b1, 16'h0040);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
